// File: rtl/pcie_tx_cpl_arb2_if.sv
// AXI-Stream TX bus carrying PCIe TLP beats between a completion source and the arbiter.
// The sink side receives beats and drives tready; the source side drives beats.
interface pcie_tx_cpl_arb2_if #(
    parameter int DATA_W = 512,
    parameter int USER_W = 10
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_W-1:0]     tdata;
    logic [DATA_W/8-1:0]   tkeep;
    logic                  tlast;
    logic [USER_W-1:0]     tuser_vendor;

    modport sink (
        input  tvalid, tdata, tkeep, tlast, tuser_vendor,
        output tready
    );

    modport source (
        output tvalid, tdata, tkeep, tlast, tuser_vendor,
        input  tready
    );
endinterface

// File: rtl/pcie_tx_cpl_arb2.sv
// Two-source, packet-atomic, round-robin TX arbiter with one registered output stage
// and per-source completed-packet counters.
module pcie_tx_cpl_arb2 #(
    parameter int DATA_W = 512,
    parameter int USER_W = 10,
    parameter int CNT_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    pcie_tx_cpl_arb2_if.sink     i_a_if,
    pcie_tx_cpl_arb2_if.sink     i_b_if,
    pcie_tx_cpl_arb2_if.source   o_tx_if,
    output logic [CNT_W-1:0]     o_pkt_cnt_a,
    output logic [CNT_W-1:0]     o_pkt_cnt_b,
    output logic                 o_busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } state_t;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t               state_q, state_d;
    logic                 last_grant_q, last_grant_d;
    logic                 tvalid_q, tvalid_d;
    logic [DATA_W-1:0]    tdata_q, tdata_d;
    logic [DATA_W/8-1:0]  tkeep_q, tkeep_d;
    logic                 tlast_q, tlast_d;
    logic [USER_W-1:0]    tuser_q, tuser_d;
    logic [CNT_W-1:0]     cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0]     cnt_b_q, cnt_b_d;
    logic                 busy_q, busy_d;

    logic grant_a_s, grant_b_s;
    logic can_load_s;
    logic rdy_a_s, rdy_b_s;
    logic acc_a_s, acc_b_s;

    // Grant selection: round-robin in IDLE, pinned to the owner while a packet is locked
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_a_if.tvalid && i_b_if.tvalid) begin
                    grant_a_s = (last_grant_q == SRC_B);
                    grant_b_s = (last_grant_q == SRC_A);
                end else begin
                    grant_a_s = i_a_if.tvalid;
                    grant_b_s = i_b_if.tvalid;
                end
            end
            LOCK_A: begin
                grant_a_s = 1'b1;
                grant_b_s = 1'b0;
            end
            LOCK_B: begin
                grant_a_s = 1'b0;
                grant_b_s = 1'b1;
            end
            default: begin
                grant_a_s = 1'b0;
                grant_b_s = 1'b0;
            end
        endcase
    end

    // Input readiness follows downstream tready directly; held low during reset
    always_comb begin
        can_load_s = ~tvalid_q | o_tx_if.tready;
        rdy_a_s    = grant_a_s & can_load_s & ~rst;
        rdy_b_s    = grant_b_s & can_load_s & ~rst;
        acc_a_s    = rdy_a_s & i_a_if.tvalid;
        acc_b_s    = rdy_b_s & i_b_if.tvalid;
    end

    assign i_a_if.tready = rdy_a_s;
    assign i_b_if.tready = rdy_b_s;

    // Next-state computation for the output register, FSM, pointer and counters
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        tvalid_d     = tvalid_q;
        tdata_d      = tdata_q;
        tkeep_d      = tkeep_q;
        tlast_d      = tlast_q;
        tuser_d      = tuser_q;
        cnt_a_d      = cnt_a_q;
        cnt_b_d      = cnt_b_q;

        if (acc_a_s) begin
            tvalid_d = 1'b1;
            tdata_d  = i_a_if.tdata;
            tkeep_d  = i_a_if.tkeep;
            tlast_d  = i_a_if.tlast;
            tuser_d  = i_a_if.tuser_vendor;
        end else if (acc_b_s) begin
            tvalid_d = 1'b1;
            tdata_d  = i_b_if.tdata;
            tkeep_d  = i_b_if.tkeep;
            tlast_d  = i_b_if.tlast;
            tuser_d  = i_b_if.tuser_vendor;
        end else if (o_tx_if.tready) begin
            tvalid_d = 1'b0;
        end else begin
            tvalid_d = tvalid_q;
        end

        case (state_q)
            IDLE: begin
                if (acc_a_s) begin
                    last_grant_d = SRC_A;
                    state_d      = i_a_if.tlast ? IDLE : LOCK_A;
                end else if (acc_b_s) begin
                    last_grant_d = SRC_B;
                    state_d      = i_b_if.tlast ? IDLE : LOCK_B;
                end else begin
                    state_d = IDLE;
                end
            end
            LOCK_A: begin
                if (acc_a_s && i_a_if.tlast) begin
                    state_d = IDLE;
                end else begin
                    state_d = LOCK_A;
                end
            end
            LOCK_B: begin
                if (acc_b_s && i_b_if.tlast) begin
                    state_d = IDLE;
                end else begin
                    state_d = LOCK_B;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (acc_a_s && i_a_if.tlast) begin
            cnt_a_d = cnt_a_q + CNT_ONE;
        end else begin
            cnt_a_d = cnt_a_q;
        end

        if (acc_b_s && i_b_if.tlast) begin
            cnt_b_d = cnt_b_q + CNT_ONE;
        end else begin
            cnt_b_d = cnt_b_q;
        end

        // Busy is registered from next-state values so it tracks the current flops exactly
        busy_d = (state_d != IDLE) | tvalid_d;
    end

    // State registers; reset abandons any packet in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= SRC_B;
            tvalid_q     <= 1'b0;
            tdata_q      <= {DATA_W{1'b0}};
            tkeep_q      <= {(DATA_W/8){1'b0}};
            tlast_q      <= 1'b0;
            tuser_q      <= {USER_W{1'b0}};
            cnt_a_q      <= {CNT_W{1'b0}};
            cnt_b_q      <= {CNT_W{1'b0}};
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            tvalid_q     <= tvalid_d;
            tdata_q      <= tdata_d;
            tkeep_q      <= tkeep_d;
            tlast_q      <= tlast_d;
            tuser_q      <= tuser_d;
            cnt_a_q      <= cnt_a_d;
            cnt_b_q      <= cnt_b_d;
            busy_q       <= busy_d;
        end
    end

    assign o_tx_if.tvalid       = tvalid_q;
    assign o_tx_if.tdata        = tdata_q;
    assign o_tx_if.tkeep        = tkeep_q;
    assign o_tx_if.tlast        = tlast_q;
    assign o_tx_if.tuser_vendor = tuser_q;
    assign o_pkt_cnt_a          = cnt_a_q;
    assign o_pkt_cnt_b          = cnt_b_q;
    assign o_busy               = busy_q;

endmodule

// File: tb/tb_pcie_tx_cpl_arb2.sv
// Directed bench for pcie_tx_cpl_arb2: ordering, packet atomicity, backpressure,
// mid-packet reset and counter wrap, with hand-computed expected beats.
module tb_pcie_tx_cpl_arb2;

    localparam int DATA_W = 64;
    localparam int USER_W = 8;
    localparam int CNT_W  = 4;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              l;
    } beat_t;

    logic clk;
    logic rst;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;
    logic busy;

    pcie_tx_cpl_arb2_if #(.DATA_W(DATA_W), .USER_W(USER_W)) a_if ();
    pcie_tx_cpl_arb2_if #(.DATA_W(DATA_W), .USER_W(USER_W)) b_if ();
    pcie_tx_cpl_arb2_if #(.DATA_W(DATA_W), .USER_W(USER_W)) o_if ();

    pcie_tx_cpl_arb2 #(.DATA_W(DATA_W), .USER_W(USER_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_a_if      (a_if),
        .i_b_if      (b_if),
        .o_tx_if     (o_if),
        .o_pkt_cnt_a (cnt_a),
        .o_pkt_cnt_b (cnt_b),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_fail   = 0;
    beat_t aq[$];
    beat_t bq[$];
    logic  a_rdy;
    logic  b_rdy;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t mk(input logic [DATA_W-1:0] d, input logic l);
        beat_t b;
        b.d = d;
        b.l = l;
        return b;
    endfunction

    // One clock: present queue heads, note readiness, advance on acceptance
    task automatic cycle();
        logic acc_a;
        logic acc_b;
        a_if.tvalid = (aq.size() > 0);
        b_if.tvalid = (bq.size() > 0);
        a_if.tdata  = (aq.size() > 0) ? aq[0].d : 64'h0;
        a_if.tlast  = (aq.size() > 0) ? aq[0].l : 1'b0;
        b_if.tdata  = (bq.size() > 0) ? bq[0].d : 64'h0;
        b_if.tlast  = (bq.size() > 0) ? bq[0].l : 1'b0;
        a_if.tuser_vendor = a_if.tdata[7:0];
        b_if.tuser_vendor = b_if.tdata[7:0];
        #1;
        a_rdy = a_if.tready;
        b_rdy = b_if.tready;
        acc_a = a_if.tvalid & a_if.tready;
        acc_b = b_if.tvalid & b_if.tready;
        @(posedge clk);
        #1;
        if (acc_a) void'(aq.pop_front());
        if (acc_b) void'(bq.pop_front());
    endtask

    task automatic do_reset();
        aq.delete();
        bq.delete();
        a_if.tvalid = 1'b0;
        b_if.tvalid = 1'b0;
        o_if.tready = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        a_if.tkeep = 8'hFF;
        b_if.tkeep = 8'hFF;
        a_if.tdata = 64'h0;
        b_if.tdata = 64'h0;
        a_if.tlast = 1'b0;
        b_if.tlast = 1'b0;
        a_if.tuser_vendor = 8'h00;
        b_if.tuser_vendor = 8'h00;
        a_if.tvalid = 1'b1;
        b_if.tvalid = 1'b1;
        o_if.tready = 1'b1;
        rst = 1'b1;
        #3;
        // Reset state, with both sources offering beats
        check_eq("rst_tvalid", {63'd0, o_if.tvalid}, 64'd0);
        check_eq("rst_tdata", o_if.tdata, 64'd0);
        check_eq("rst_tkeep", {56'd0, o_if.tkeep}, 64'd0);
        check_eq("rst_tlast", {63'd0, o_if.tlast}, 64'd0);
        check_eq("rst_tuser", {56'd0, o_if.tuser_vendor}, 64'd0);
        check_eq("rst_cnt_a", {60'd0, cnt_a}, 64'd0);
        check_eq("rst_cnt_b", {60'd0, cnt_b}, 64'd0);
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_a_rdy", {63'd0, a_if.tready}, 64'd0);
        check_eq("rst_b_rdy", {63'd0, b_if.tready}, 64'd0);
        @(posedge clk);
        do_reset();

        // Single A beat passes through unchanged one cycle later
        aq.push_back(mk(64'h11, 1'b1));
        cycle();
        check_eq("t1_a_rdy", {63'd0, a_rdy}, 64'd1);
        check_eq("t1_tvalid", {63'd0, o_if.tvalid}, 64'd1);
        check_eq("t1_tdata", o_if.tdata, 64'h11);
        check_eq("t1_tkeep", {56'd0, o_if.tkeep}, 64'hFF);
        check_eq("t1_tlast", {63'd0, o_if.tlast}, 64'd1);
        check_eq("t1_tuser", {56'd0, o_if.tuser_vendor}, 64'h11);
        check_eq("t1_cnt_a", {60'd0, cnt_a}, 64'd1);
        check_eq("t1_cnt_b", {60'd0, cnt_b}, 64'd0);
        cycle();
        check_eq("t1_drain", {63'd0, o_if.tvalid}, 64'd0);

        // Fairness: A0 B0 A1 B1 A2 B2 back to back
        do_reset();
        for (int k = 0; k < 3; k++) begin
            aq.push_back(mk(64'hA0 + 64'(k), 1'b1));
            bq.push_back(mk(64'hB0 + 64'(k), 1'b1));
        end
        for (int k = 0; k < 6; k++) begin
            logic [63:0] exp_d;
            exp_d = (k % 2 == 0) ? (64'hA0 + 64'(k / 2)) : (64'hB0 + 64'(k / 2));
            cycle();
            check_eq($sformatf("rr_valid%0d", k), {63'd0, o_if.tvalid}, 64'd1);
            check_eq($sformatf("rr_data%0d", k), o_if.tdata, exp_d);
        end
        check_eq("rr_cnt_a", {60'd0, cnt_a}, 64'd3);
        check_eq("rr_cnt_b", {60'd0, cnt_b}, 64'd3);

        // Packet atomicity: 3-beat A packet, B held off until A's tlast
        do_reset();
        aq.push_back(mk(64'hA1, 1'b0));
        aq.push_back(mk(64'hA2, 1'b0));
        aq.push_back(mk(64'hA3, 1'b1));
        bq.push_back(mk(64'hB1, 1'b1));
        cycle();
        check_eq("pk_data0", o_if.tdata, 64'hA1);
        check_eq("pk_b_rdy0", {63'd0, b_rdy}, 64'd0);
        check_eq("pk_busy0", {63'd0, busy}, 64'd1);
        cycle();
        check_eq("pk_data1", o_if.tdata, 64'hA2);
        check_eq("pk_b_rdy1", {63'd0, b_rdy}, 64'd0);
        cycle();
        check_eq("pk_data2", o_if.tdata, 64'hA3);
        check_eq("pk_last2", {63'd0, o_if.tlast}, 64'd1);
        check_eq("pk_b_rdy2", {63'd0, b_rdy}, 64'd0);
        cycle();
        check_eq("pk_data3", o_if.tdata, 64'hB1);
        check_eq("pk_valid3", {63'd0, o_if.tvalid}, 64'd1);
        check_eq("pk_b_rdy3", {63'd0, b_rdy}, 64'd1);

        // Backpressure: output held and A stalled for 5 cycles
        do_reset();
        aq.push_back(mk(64'hC0, 1'b1));
        aq.push_back(mk(64'hC1, 1'b1));
        o_if.tready = 1'b0;
        cycle();
        check_eq("bp_first", o_if.tdata, 64'hC0);
        for (int k = 0; k < 5; k++) begin
            cycle();
            check_eq($sformatf("bp_a_rdy%0d", k), {63'd0, a_rdy}, 64'd0);
            check_eq($sformatf("bp_hold%0d", k), o_if.tdata, 64'hC0);
            check_eq($sformatf("bp_valid%0d", k), {63'd0, o_if.tvalid}, 64'd1);
        end
        o_if.tready = 1'b1;
        cycle();
        check_eq("bp_next", o_if.tdata, 64'hC1);
        check_eq("bp_next_valid", {63'd0, o_if.tvalid}, 64'd1);
        cycle();
        check_eq("bp_drain", {63'd0, o_if.tvalid}, 64'd0);
        check_eq("bp_cnt_a", {60'd0, cnt_a}, 64'd2);

        // Reset in the middle of a 4-beat B packet
        do_reset();
        bq.push_back(mk(64'hD1, 1'b0));
        bq.push_back(mk(64'hD2, 1'b0));
        bq.push_back(mk(64'hD3, 1'b0));
        bq.push_back(mk(64'hD4, 1'b1));
        cycle();
        cycle();
        check_eq("mr_pre_data", o_if.tdata, 64'hD2);
        check_eq("mr_pre_busy", {63'd0, busy}, 64'd1);
        b_if.tvalid = 1'b1;
        b_if.tdata  = 64'hD3;
        rst = 1'b1;
        #1;
        check_eq("mr_tvalid", {63'd0, o_if.tvalid}, 64'd0);
        check_eq("mr_tdata", o_if.tdata, 64'd0);
        check_eq("mr_busy", {63'd0, busy}, 64'd0);
        check_eq("mr_b_rdy", {63'd0, b_if.tready}, 64'd0);
        bq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        aq.push_back(mk(64'hA5, 1'b1));
        bq.push_back(mk(64'hB9, 1'b1));
        cycle();
        check_eq("mr_first_a", o_if.tdata, 64'hA5);
        cycle();
        check_eq("mr_then_b", o_if.tdata, 64'hB9);
        cycle();
        check_eq("mr_drain", {63'd0, o_if.tvalid}, 64'd0);
        check_eq("mr_cnt_b", {60'd0, cnt_b}, 64'd1);

        // 4-bit counter wrap: 16 packets read 0, 17th reads 1
        do_reset();
        for (int k = 0; k < 17; k++) bq.push_back(mk(64'hE0 + 64'(k), 1'b1));
        for (int k = 0; k < 16; k++) cycle();
        check_eq("wrap_16", {60'd0, cnt_b}, 64'd0);
        cycle();
        check_eq("wrap_17", {60'd0, cnt_b}, 64'd1);
        check_eq("wrap_data17", o_if.tdata, 64'hF0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pcie_tx_cpl_arb2.md
# pcie_tx_cpl_arb2

Two-input, packet-atomic, round-robin arbiter that merges two PCIe SS AXI-Stream TX sources onto one TX port. It sits directly downstream of the MMIO completion responders, for example a null host-exerciser port plus a second AFU function. It feeds the single `o_tx_if` toward the PF/VF mux. Each input packet (header beat through `tlast` beat) is forwarded contiguously through one registered output stage. Per-source completed-packet counters are provided.

## Interface
Parameters:
- `DATA_W`, default `ofs_fim_cfg_pkg::PCIE_TDATA_WIDTH` (512): tdata width; tkeep is DATA_W/8.
- `USER_W`, default `ofs_fim_cfg_pkg::PCIE_TUSER_WIDTH`: tuser_vendor width.
- `CNT_W`, default 32: packet counter width.

Ports:
- `clk`  in  1  — single clock; all logic is synchronous to its rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `i_a_if`  `pcie_ss_axis_if.sink`  DATA_W/USER_W  — source A; highest priority immediately after reset.
- `i_b_if`  `pcie_ss_axis_if.sink`  DATA_W/USER_W  — source B.
- `o_tx_if`  `pcie_ss_axis_if.source`  DATA_W/USER_W  — merged TX stream.
- `o_pkt_cnt_a`  out  CNT_W  — packets (tlast beats) accepted from A.
- `o_pkt_cnt_b`  out  CNT_W  — packets accepted from B.
- `o_busy`  out  1  — 1 while a packet is locked or the output register holds a beat.

## Operation
- State machine states:
  - `IDLE`: no packet in progress.
  - `LOCK_A`: A is mid-packet.
  - `LOCK_B`: B is mid-packet.
- Round-robin pointer `last_grant`; reset value is B, so A wins first.
- Grant in `IDLE` (combinational):
  - Only one tvalid asserted: grant that source.
  - Both asserted: grant the source that is not `last_grant`.
  - Neither asserted: no grant.
- Grant in `LOCK_x`: fixed to x. The other source's tvalid is ignored.
- `can_load = ~o_tx_if.tvalid | o_tx_if.tready`.
- tready per input:
  - Granted source: `tready = can_load`.
  - Ungranted source: `tready = 0`.
- Beat accepted when the granted source has tvalid & tready. On acceptance:
  - tdata, tkeep, tuser_vendor and tlast are loaded into the output register.
  - `o_tx_if.tvalid` is set.
- Output register clears tvalid when `o_tx_if.tready` is high and no new beat is loaded.
- Transitions:
  - `IDLE` → `LOCK_x` on an accepted first beat from x with tlast=0.
  - `IDLE` stays `IDLE` on an accepted single-beat packet (tlast=1).
  - `LOCK_x` → `IDLE` on an accepted x beat with tlast=1.
- `last_grant` updates to x when x's first beat is accepted in `IDLE`.
- Counters:
  - `o_pkt_cnt_x` increments by 1 on every accepted x beat with tlast=1.
  - Counters wrap modulo 2^CNT_W. No saturation.
- Fields are passed through unmodified; the block never inspects header contents.
- Reset, asynchronous and allowed mid-packet:
  - State goes to `IDLE`, `last_grant` to B.
  - Output register and counters go to 0.
  - Any partially forwarded packet is abandoned; no trailing beats are emitted.

## Timing
- Reset values: `o_tx_if.tvalid`=0, `tlast`=0, `tdata`=0, `tkeep`=0, `tuser_vendor`=0; `o_pkt_cnt_a`=`o_pkt_cnt_b`=0; `o_busy`=0. Input treadys are 0 while `rst`=1.
- Latency: a beat accepted at the cycle-N edge is presented on `o_tx_if` during cycle N+1.
- Throughput: 1 beat/cycle sustained while `o_tx_if.tready`=1.
- Packet switch: no bubble. If A's tlast is accepted at cycle N and B is waiting, B's first beat is accepted at N+1.
- Input tready depends combinationally on `o_tx_if.tready` (no skid buffer). The downstream tready is not registered here.
- Backpressure: while `o_tx_if.tvalid`=1 and `o_tx_if.tready`=0:
  - The output register holds stable.
  - Both input treadys are 0.
- Fairness: with both sources continuously offering single-beat packets, grants alternate A, B, A, B.

## Test plan
- Single A beat, tdata=0x11, tkeep all ones, tlast=1, `o_tx_if.tready`=1 → the beat appears on `o_tx_if` one cycle later unchanged; `o_pkt_cnt_a`=1, `o_pkt_cnt_b`=0.
- After reset, A and B each continuously offer single-beat packets (tdata 0xA0.., 0xB0..) → output order A0, B0, A1, B1, …; no idle cycles.
- A sends a 3-beat packet (A_h, A_d0, A_d1) with B valid from the first cycle → output A_h, A_d0, A_d1, B_h with no interleave and no bubble; B's tready stays 0 until A's tlast is accepted.
- Output valid with `o_tx_if.tready`=0 for 5 cycles, A holding a beat → output data stable, A tready=0 for all 5 cycles; when ready rises, all beats are delivered once with none dropped or duplicated.
- Assert `rst` after the 2nd beat of a 4-beat B packet → all outputs 0 immediately; after release, an A single-beat packet is granted first; no remaining B beats appear unless B resends.
- `CNT_W`=4, 17 single-beat packets from B → `o_pkt_cnt_b` reads 0 after the 16th and 1 after the 17th.
